// File: rtl/corevx_cache_ptw_pkg.sv
// -----------------------------------------------------------------------------
// corevx_cache_ptw_pkg
// Shared definitions for the Sv32 page table walker:
//   - accesstag_t   : PTE[7:0] bit layout (V,R,W,X,U,G,A,D), also used by
//                     corevx_cache_pagefault when it checks stored tags
//   - ST_*          : walker state encoding
//   - pte_addr()    : PTE physical byte address for one walk level
// -----------------------------------------------------------------------------
package corevx_cache_ptw_pkg;

    // Accesstag bit layout, MSB first: D=7 A=6 G=5 U=4 X=3 W=2 R=1 V=0
    typedef struct packed {
        logic d;
        logic a;
        logic g;
        logic u;
        logic x;
        logic w;
        logic r;
        logic v;
    } accesstag_t;

    // Walker state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Sv32 PTEs are 4 bytes, indexed by one 10-bit VPN field inside a 4 KiB table
    function automatic logic [33:0] pte_addr(input logic [21:0] table_ppn,
                                             input logic [9:0]  vpn_field);
        return {table_ppn, vpn_field, 2'b00};
    endfunction

endpackage

// File: rtl/corevx_ptw_pte_decode.sv
// -----------------------------------------------------------------------------
// corevx_ptw_pte_decode
// Combinational classification of one Sv32 PTE returned during a walk.
// Ports:
//   i_pte        in  32  PTE data from memory
//   i_level      in  1   walk level the PTE was read at (1 = root)
//   i_vpn0       in  10  VPN[0] of the address being translated
//   o_leaf       out 1   valid, well-formed leaf
//   o_pointer    out 1   pointer to the next level (only possible at level 1)
//   o_pagefault  out 1   structural fault
//   o_ppn        out 22  leaf PPN (0 unless o_leaf)
//   o_tag        out 8   leaf accesstag (0 unless o_leaf)
// Exactly one of o_leaf / o_pointer / o_pagefault is high.
// -----------------------------------------------------------------------------
module corevx_ptw_pte_decode
    import corevx_cache_ptw_pkg::*;
(
    input  logic [31:0] i_pte,
    input  logic        i_level,
    input  logic [9:0]  i_vpn0,
    output logic        o_leaf,
    output logic        o_pointer,
    output logic        o_pagefault,
    output logic [21:0] o_ppn,
    output logic [7:0]  o_tag
);

    accesstag_t w_tag;
    logic       w_invalid;
    logic       w_leaf_type;
    logic       w_misaligned;
    logic       w_unused_rsw;

    assign w_tag        = accesstag_t'(i_pte[7:0]);
    // W without R is a reserved encoding and faults like an invalid entry
    assign w_invalid    = (!w_tag.v) || ((!w_tag.r) && w_tag.w);
    assign w_leaf_type  = w_tag.r || w_tag.x;
    // A megapage must be 4 MiB aligned: its low PPN field has to be zero
    assign w_misaligned = i_level && (i_pte[19:10] != 10'd0);
    // RSW bits are software-owned and carry no meaning for the walk
    assign w_unused_rsw = ^i_pte[9:8];

    // Classify the PTE in the fault > leaf > pointer priority order
    always_comb begin
        o_leaf      = 1'b0;
        o_pointer   = 1'b0;
        o_pagefault = 1'b0;
        o_ppn       = 22'd0;
        o_tag       = 8'd0;
        if (w_invalid) begin
            o_pagefault = 1'b1;
        end else if (w_leaf_type) begin
            if (w_misaligned) begin
                o_pagefault = 1'b1;
            end else begin
                o_leaf = 1'b1;
                o_tag  = i_pte[7:0];
                if (i_level) begin
                    o_ppn = {i_pte[31:20], i_vpn0};
                end else begin
                    o_ppn = i_pte[31:10];
                end
            end
        end else if (i_level) begin
            o_pointer = 1'b1;
        end else begin
            o_pagefault = 1'b1;
        end
    end

endmodule

// File: rtl/corevx_cache_ptw.sv
// -----------------------------------------------------------------------------
// corevx_cache_ptw
// Sv32 hardware page table walker. On a TLB miss it reads PTEs one level at a
// time and returns the leaf PPN plus the 8-bit accesstag. Only structural
// faults and bus errors are reported; permission checks happen later on the
// stored accesstag.
// Ports:
//   i_clk, i_rst_n                    clock, synchronous active-low reset
//   i_satp_ppn[21:0]                  root table PPN, sampled at acceptance
//   i_resolve_request                 start a walk (accepted only when idle)
//   i_resolve_virtual_address[19:0]   {vpn1, vpn0}, sampled at acceptance
//   o_resolve_busy                    walk in progress (through the done cycle)
//   o_resolve_done                    one-cycle completion pulse
//   o_resolve_pagefault               structural fault (with done)
//   o_resolve_access_fault            bus error on a PTE read (with done)
//   o_resolve_physical_address[21:0]  leaf PPN (0 on fault)
//   o_resolve_accesstag[7:0]          leaf PTE[7:0] (0 on fault)
//   o_m_req / i_m_ready               PTE read request handshake
//   o_m_address[33:0]                 PTE physical byte address
//   i_m_rvalid, i_m_rdata[31:0]       read response
//   i_m_rerror                        bus error (with i_m_rvalid)
// All outputs are registered.
// -----------------------------------------------------------------------------
module corevx_cache_ptw
    import corevx_cache_ptw_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [21:0] i_satp_ppn,
    input  logic        i_resolve_request,
    input  logic [19:0] i_resolve_virtual_address,
    output logic        o_resolve_busy,
    output logic        o_resolve_done,
    output logic        o_resolve_pagefault,
    output logic        o_resolve_access_fault,
    output logic [21:0] o_resolve_physical_address,
    output logic [7:0]  o_resolve_accesstag,
    output logic        o_m_req,
    input  logic        i_m_ready,
    output logic [33:0] o_m_address,
    input  logic        i_m_rvalid,
    input  logic [31:0] i_m_rdata,
    input  logic        i_m_rerror
);

    logic [1:0]  r_state;
    logic        r_level;
    logic [9:0]  r_vpn0;
    logic        r_busy;
    logic        r_done;
    logic        r_pagefault;
    logic        r_access_fault;
    logic [21:0] r_ppn;
    logic [7:0]  r_tag;
    logic        r_m_req;
    logic [33:0] r_m_address;

    logic        w_leaf;
    logic        w_pointer;
    logic        w_pagefault;
    logic [21:0] w_ppn;
    logic [7:0]  w_tag;

    corevx_ptw_pte_decode u_pte_decode (
        .i_pte       (i_m_rdata),
        .i_level     (r_level),
        .i_vpn0      (r_vpn0),
        .o_leaf      (w_leaf),
        .o_pointer   (w_pointer),
        .o_pagefault (w_pagefault),
        .o_ppn       (w_ppn),
        .o_tag       (w_tag)
    );

    // Walk state machine, memory request and result registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_level        <= 1'b0;
            r_vpn0         <= 10'd0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pagefault    <= 1'b0;
            r_access_fault <= 1'b0;
            r_ppn          <= 22'd0;
            r_tag          <= 8'd0;
            r_m_req        <= 1'b0;
            r_m_address    <= 34'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_resolve_request) begin
                        // The level-1 address is formed here, so satp and
                        // vpn1 need no storage beyond the address register.
                        r_vpn0      <= i_resolve_virtual_address[9:0];
                        r_level     <= 1'b1;
                        r_m_address <= pte_addr(i_satp_ppn,
                                                i_resolve_virtual_address[19:10]);
                        r_m_req     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // i_m_rvalid is deliberately not looked at here: any
                    // response seen before acceptance is stale.
                    if (i_m_ready) begin
                        r_m_req <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_m_rvalid) begin
                        if (i_m_rerror) begin
                            r_access_fault <= 1'b1;
                            r_pagefault    <= 1'b0;
                            r_ppn          <= 22'd0;
                            r_tag          <= 8'd0;
                            r_done         <= 1'b1;
                            r_state        <= ST_DONE;
                        end else if (w_pointer) begin
                            r_level     <= 1'b0;
                            r_m_address <= pte_addr(i_m_rdata[31:10], r_vpn0);
                            r_m_req     <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end else begin
                            // Anything that is not a clean leaf completes
                            // as a pagefault; decode already zeroes ppn/tag.
                            r_access_fault <= 1'b0;
                            r_pagefault    <= w_pagefault || (!w_leaf);
                            r_ppn          <= w_ppn;
                            r_tag          <= w_tag;
                            r_done         <= 1'b1;
                            r_state        <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_m_req <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_resolve_busy             = r_busy;
    assign o_resolve_done             = r_done;
    assign o_resolve_pagefault        = r_pagefault;
    assign o_resolve_access_fault     = r_access_fault;
    assign o_resolve_physical_address = r_ppn;
    assign o_resolve_accesstag        = r_tag;
    assign o_m_req                    = r_m_req;
    assign o_m_address                = r_m_address;

endmodule
